vector_activation: RTL
======================

// Module: vector_activation
// PURPOSE
//  Downstream of the dot-product engine. Captures the packed NROW-element pre-activation vector on the engine's
//  dataReady strobe, then applies a piecewise-linear hard sigmoid or hard tanh to one element per cycle.
//  Presents the activated vector with a one-cycle outputValid strobe to the gate/state-update stage.
//  The output buffer holds its value while the next vector is processed.
// PARAMETERS
//  NROW  16  elements per vector
//  QN    6   integer bits (excl. sign)
//  QM    11  fractional bits; BITWIDTH=QN+QM+1, LAYER_BITWIDTH=BITWIDTH*NROW, ONE=1<<QM
// PORTS
//  clk           in   1               rising-edge clock
//  reset         in   1               asynchronous, active-low reset
//  dataReady     in   1               1-cycle strobe: inputVector valid this cycle
//  inputVector   in   LAYER_BITWIDTH  signed packed elements, element k at [k*BITWIDTH +: BITWIDTH]
//  actSel        in   1               0=hard sigmoid, 1=hard tanh; sampled with dataReady
//  busy          out  1               vector being processed
//  outputValid   out  1               1-cycle strobe: outputVector updated
//  overrun       out  1               sticky: dataReady arrived while busy
//  outputVector  out  LAYER_BITWIDTH  signed packed activated elements
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, busy=0, outputValid=0, overrun=0, outputVector=0, index=0.
//  - FSM states:
//      IDLE -> CALC on dataReady: inputVector and actSel are captured into a working register; index=0.
//      CALC: each edge activates element[index] in place and increments index.
//            Index NROW-1 -> DONE; the same edge copies the full working register to outputVector.
//      DONE: outputValid=1 for exactly this cycle; -> IDLE, or -> CALC if dataReady is high (back-to-back).
//  - Latency: strobe at edge T0; outputValid high in the cycle after edge T0+NROW. busy=1 in CALC only.
//  - dataReady while in CALC: ignored (no capture, no disturbance); overrun set. Only reset clears overrun.
//  - Hard sigmoid: y = sat((x>>>2) + ONE/2, 0, ONE). Arithmetic shift truncates toward -inf; the sum is
//    computed at BITWIDTH+1 bits before clamping.
//  - Hard tanh: y = sat(x, -ONE, ONE).
//  - outputVector changes only on the completion edge and is stable between outputValid strobes.
//  - Reset mid-CALC: the vector is discarded and no outputValid is produced.
// CONFIGURATION
//  ACT_BIAS_EN defined:
//   - Adds input port biasVector [LAYER_BITWIDTH], captured together with inputVector on dataReady.
//   - Each element becomes x' = sat(x + b) to the signed BITWIDTH range before activation.
//   - Latency is unchanged.
//  ACT_BIAS_EN undefined: no biasVector port; x' = x.
// TESTING (QN=6, QM=11, NROW=16, ONE=2048)
//  1. Reset mid-CALC (reset=0 at index 5) -> all outputs 0 immediately; no outputValid after release.
//  2. Sigmoid, elements {0, 4096, 8192, -8192, -3}:
//     -> {1024, 2048, 2048, 0, 1023}; outputValid exactly 17 cycles after the strobe edge.
//  3. Tanh, elements {1000, -5000, 2048, -2048} -> {1000, -2048, 2048, -2048}.
//  4. Second dataReady 4 cycles after the first -> overrun=1; first result correct; no second outputValid.
//  5. dataReady held high in DONE -> next vector captured; outputValid strobes 17 cycles apart.
//  6. ACT_BIAS_EN, sigmoid: x=131071 with b=100 -> x'=131071 -> 2048; x=-100 with b=100 -> 1024.

Source files
------------

// File: rtl/vector_activation.sv
// rtl/vector_activation.sv - captures a packed vector and applies hard sigmoid/tanh one element per cycle
// Optional ACT_BIAS_EN adds a per-element saturating bias applied before activation.
module vector_activation #(
  parameter int NROW = 16,
  parameter int QN = 6,
  parameter int QM = 11,
  localparam int BITWIDTH = QN + QM + 1,
  localparam int LAYER_BITWIDTH = BITWIDTH * NROW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dataReady,
  input  logic [LAYER_BITWIDTH-1:0] inputVector,
`ifdef ACT_BIAS_EN
  input  logic [LAYER_BITWIDTH-1:0] biasVector,
`endif
  input  logic                      actSel,
  output logic                      busy,
  output logic                      outputValid,
  output logic                      overrun,
  output logic [LAYER_BITWIDTH-1:0] outputVector
);

  localparam int IDXW = (NROW > 1) ? $clog2(NROW) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NROW - 1);
  localparam logic signed [BITWIDTH-1:0] POS_ONE = BITWIDTH'(1 << QM);
  localparam logic signed [BITWIDTH-1:0] NEG_ONE = -POS_ONE;
  localparam logic signed [BITWIDTH:0] ONE_W = (BITWIDTH + 1)'(1 << QM);
  localparam logic signed [BITWIDTH:0] HALF_W = (BITWIDTH + 1)'(1 << (QM - 1));

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                     state;
  logic [IDXW-1:0]            idx;
  logic                       sel_q;
  logic signed [BITWIDTH-1:0] work [NROW];
  logic signed [BITWIDTH-1:0] cur_x;
  logic signed [BITWIDTH-1:0] act_val;
`ifdef ACT_BIAS_EN
  logic signed [BITWIDTH-1:0] bias [NROW];
  logic [BITWIDTH:0]          sum;
`endif

  // Sigmoid sum is one bit wider than the element so the clamp sees the true sign.
  function automatic logic signed [BITWIDTH-1:0] activate(input logic signed [BITWIDTH-1:0] x,
                                                          input logic tanh_sel);
    logic signed [BITWIDTH:0] s;
    activate = x;
    if (tanh_sel) begin
      if (x > POS_ONE) activate = POS_ONE;
      else if (x < NEG_ONE) activate = NEG_ONE;
    end else begin
      s = ($signed({x[BITWIDTH-1], x}) >>> 2) + HALF_W;
      if (s[BITWIDTH]) activate = '0;
      else if (s > ONE_W) activate = POS_ONE;
      else activate = s[BITWIDTH-1:0];
    end
  endfunction

  always_comb begin
    cur_x = work[idx];
`ifdef ACT_BIAS_EN
    sum = {work[idx][BITWIDTH-1], work[idx]} + {bias[idx][BITWIDTH-1], bias[idx]};
    if (sum[BITWIDTH] != sum[BITWIDTH-1])
      cur_x = sum[BITWIDTH] ? {1'b1, {(BITWIDTH-1){1'b0}}} : {1'b0, {(BITWIDTH-1){1'b1}}};
    else
      cur_x = sum[BITWIDTH-1:0];
`endif
    act_val = activate(cur_x, sel_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      idx          <= '0;
      sel_q        <= 1'b0;
      busy         <= 1'b0;
      outputValid  <= 1'b0;
      overrun      <= 1'b0;
      outputVector <= '0;
      for (int k = 0; k < NROW; k++) begin
        work[k] <= '0;
`ifdef ACT_BIAS_EN
        bias[k] <= '0;
`endif
      end
    end else begin
      outputValid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (dataReady) begin
            for (int k = 0; k < NROW; k++) begin
              work[k] <= inputVector[k*BITWIDTH +: BITWIDTH];
`ifdef ACT_BIAS_EN
              bias[k] <= biasVector[k*BITWIDTH +: BITWIDTH];
`endif
            end
            sel_q <= actSel;
            idx   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (dataReady) overrun <= 1'b1;
          work[idx] <= act_val;
          if (idx == LAST) begin
            // The last element is merged in directly since work[] updates on this same edge.
            for (int k = 0; k < NROW; k++)
              outputVector[k*BITWIDTH +: BITWIDTH] <= (idx == IDXW'(k)) ? act_val : work[k];
            idx         <= '0;
            busy        <= 1'b0;
            outputValid <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
